// File: rtl/aes_block_arbiter.sv
// Two-channel arbiter in front of a single AES block engine: round-robin issue with message lock,
// and a tag FIFO that steers in-order engine results back to the issuing channel. ARB_STATS_EN adds issue counters.
module aes_block_arbiter #(
    parameter int BLOCK_W   = 128,
    parameter int TAG_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BLOCK_W-1:0] req0_block,
    input  logic               req0_last,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [BLOCK_W-1:0] req1_block,
    input  logic               req1_last,
    output logic               eng_in_valid,
    input  logic               eng_in_ready,
    output logic [BLOCK_W-1:0] eng_in_block,
    input  logic               eng_out_valid,
    output logic               eng_out_ready,
    input  logic [BLOCK_W-1:0] eng_out_block,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [BLOCK_W-1:0] rsp0_block,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [BLOCK_W-1:0] rsp1_block,
    output logic               busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]        stat_issue0,
    output logic [31:0]        stat_issue1
`endif
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic tag_full, tag_empty;
    logic sel, sel_valid, sel_last;
    logic issue, pop, head;

    // A held lock restricts selection to the owning channel until its last block issues.
    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        case (state_q)
            ST_LOCK0: begin
                sel       = 1'b0;
                sel_valid = req0_valid;
            end
            ST_LOCK1: begin
                sel       = 1'b1;
                sel_valid = req1_valid;
            end
            default: begin
                sel       = (req0_valid & req1_valid) ? prio_q : req1_valid;
                sel_valid = req0_valid | req1_valid;
            end
        endcase
    end

    assign tag_full  = (cnt_q == CNT_W'(TAG_DEPTH));
    assign tag_empty = (cnt_q == '0);
    assign sel_last  = sel ? req1_last : req0_last;

    assign eng_in_valid = sel_valid & ~tag_full & ~rst;
    assign eng_in_block = sel ? req1_block : req0_block;
    assign req0_ready   = ~sel & eng_in_ready & ~tag_full & ~rst;
    assign req1_ready   =  sel & eng_in_ready & ~tag_full & ~rst;
    assign issue        = eng_in_valid & eng_in_ready;

    // Results come back in issue order, so the FIFO head names the owner of the current result.
    assign head          = tag_mem_q[rd_ptr_q];
    assign eng_out_ready = ~tag_empty & (head ? rsp1_ready : rsp0_ready) & ~rst;
    assign rsp0_valid    = eng_out_valid & ~tag_empty & ~head & ~rst;
    assign rsp1_valid    = eng_out_valid & ~tag_empty &  head & ~rst;
    assign rsp0_block    = eng_out_block;
    assign rsp1_block    = eng_out_block;
    assign pop           = eng_out_valid & eng_out_ready;

    assign busy = (state_q != ST_IDLE) | ~tag_empty;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (issue) begin
            if (sel_last) begin
                state_d = ST_IDLE;
                prio_d  = ~sel;
            end else begin
                state_d = sel ? ST_LOCK1 : ST_LOCK0;
            end
        end
    end

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (issue) begin
            tag_mem_d[wr_ptr_q] = sel;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            tag_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            tag_mem_q <= tag_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stat0_q, stat0_d;
    logic [31:0] stat1_q, stat1_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (issue && !sel) stat0_d = sat_inc(stat0_q);
        if (issue &&  sel) stat1_d = sat_inc(stat1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat_issue0 = stat0_q;
    assign stat_issue1 = stat1_q;
`endif

endmodule

// File: doc/aes_block_arbiter.md
Name: aes_block_arbiter

Overview:
- Shares one 128-bit AES block engine between two independent block streams (channel 0, channel 1).
- Each channel is typically fed by a word-to-block adapter. Responses return through block-to-word adapters.
- Grants the engine input round-robin, with message lock: a chained message is never interleaved.
- Records the issuing channel of every accepted block in a tag FIFO, and steers engine results back to that channel in order.

Parameters:
- BLOCK_W, 128, block data width.
- TAG_DEPTH, 4, maximum outstanding blocks inside the engine; power of two, 2..16.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  channel 0 block available
- req0_ready  output  1  channel 0 block accepted
- req0_block  input  BLOCK_W  channel 0 block
- req0_last  input  1  final block of channel 0 message
- req1_valid / req1_ready / req1_block / req1_last  as channel 0, for channel 1
- eng_in_valid  output  1  block to engine valid
- eng_in_ready  input  1  engine accepts block
- eng_in_block  output  BLOCK_W  muxed block to engine
- eng_out_valid  input  1  engine result valid
- eng_out_ready  output  1  result consumed
- eng_out_block  input  BLOCK_W  engine result
- rsp0_valid  output  1  result for channel 0
- rsp0_ready  input  1  channel 0 sink ready
- rsp0_block  output  BLOCK_W  result data, channel 0
- rsp1_valid / rsp1_ready / rsp1_block  as channel 0, for channel 1
- busy  output  1  lock held or tag FIFO non-empty

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk):
  - state=IDLE, prio=0, tag FIFO empty.
  - All valid/ready outputs 0, busy=0.
- Issue path:
  - Combinational, zero latency: eng_in_valid/eng_in_block come from the selected channel's req.
  - The selected channel's reqN_ready = eng_in_ready & !tag_full. The unselected channel's ready=0.
  - eng_in_valid = sel_valid & !tag_full.
  - Issue event = eng_in_valid & eng_in_ready.
- State machine:
  - IDLE:
    - Both valid: select channel prio. One valid: select it. None: eng_in_valid=0.
    - On issue with last=0: go to LOCKn for the selected n.
    - On issue with last=1: stay IDLE, prio <= other channel.
  - LOCKn:
    - Select only channel n. The other channel waits even if valid.
    - On issue with reqn_last=1: go to IDLE, prio <= other channel.
- Tag FIFO:
  - 1-bit entries, depth TAG_DEPTH. Push issuing channel on issue.
  - tag_full when count==TAG_DEPTH. Push is blocked when full, even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo TAG_DEPTH.
- Return path:
  - Head tag h selects the response channel.
  - rsp_h_valid = eng_out_valid & !tag_empty; rsp_h_block = eng_out_block.
  - The other channel's rsp valid=0.
  - eng_out_ready = !tag_empty & rsp_h_ready.
  - Pop on eng_out_valid & eng_out_ready.
  - eng_out_valid while the FIFO is empty: eng_out_ready=0, result held, no response.
- Backpressure on one response channel stalls all returns (in-order engine). Issue continues until tag_full.
- busy = (state!=IDLE) | !tag_empty.
- Reset mid-operation: lock, prio and tags are discarded. The engine must be reset in the same cycle.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds output ports stat_issue0 and stat_issue1 (32 bits each). Each counts issue events per channel, saturating at 0xFFFFFFFF. Reset value 0.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Both channels valid, single-block messages (last=1), engine always ready: issues alternate ch0,ch1,ch0,ch1 starting with ch0; responses return to matching rsp channels in the same order.
- ch0 sends a 3-block message (last=0,0,1) while ch1 is valid throughout: engine sees ch0 x3, then ch1; req1_ready stays 0 during LOCK0.
- Engine never returns results (eng_out_valid=0), TAG_DEPTH=4: exactly 4 issues, then eng_in_valid=0 and both reqN_ready=0. One result popped -> exactly one more issue.
- rsp0_ready=0 with ch0 tag at head: eng_out_ready=0; rsp1_valid stays 0 even though the next tag is ch1; releasing rsp0_ready drains ch0 then ch1.
- Assert rst while in LOCK1 with 2 outstanding tags: next cycle state=IDLE, busy=0, all readies/valids 0; first post-reset grant goes to ch0.
- With ARB_STATS_EN: 5 ch0 and 3 ch1 single-block issues -> stat_issue0=5, stat_issue1=3.
